i_rd_addr_gen: RTL and testbench
================================

Name: i_rd_addr_gen

Overview:
Read-side address generator that streams an image out of SRAM in row-major order, pixel by pixel. It is the counterpart of the image-write column counter: it keeps column and row counters with rollover and drives a request/acknowledge read handshake toward the SRAM controller. It also gives row and frame completion strobes to the downstream pixel consumer.

Parameters:
WIDTH_BITS, 13, width of the img_width, img_height, col and row fields (maximum dimension 8191)
ADDR_BITS, 24, SRAM word address width

Ports:
clk  input  1  system clock, rising-edge
clear  input  1  synchronous active-high reset; aborts any frame in progress
start  input  1  single-cycle pulse that begins a frame read; honoured only in IDLE
img_width  input  WIDTH_BITS  pixels per row; sampled on an accepted start
img_height  input  WIDTH_BITS  rows per frame; sampled on an accepted start
base_addr  input  ADDR_BITS  SRAM address of pixel (0,0); sampled on an accepted start
rd_ack  input  1  SRAM controller accepted the current request
rd_req  output  1  read request valid
rd_addr  output  ADDR_BITS  address of the current request
col  output  WIDTH_BITS  column index of the current request
row  output  WIDTH_BITS  row index of the current request
row_done  output  1  one-cycle pulse after the last pixel of a row is acknowledged
frame_done  output  1  one-cycle pulse when the frame completes
busy  output  1  high in READ and DONE

Behaviour:
- Single clock domain (clk). clear is synchronous and active-high. clear has priority over every other input.
- Reset and clear values: state=IDLE; rd_req=0; rd_addr=0; col=0; row=0; row_done=0; frame_done=0; busy=0; latched width, height and address registers=0.
- States:
  - IDLE: waits for start.
  - READ: issues requests.
  - DONE: single-cycle state that asserts frame_done.
- IDLE with start=1 and both dimensions nonzero (start sampled at edge k):
  - Latch img_width, img_height and base_addr.
  - From edge k+1: state=READ, rd_req=1, rd_addr=base_addr, col=0, row=0, busy=1.
- IDLE with start=1 and img_width==0 or img_height==0:
  - Go to DONE; no request is ever issued.
  - frame_done=1 and busy=1 for cycle k+1; IDLE at k+2.
- READ handshake:
  - rd_req stays high, and rd_addr/col/row stay stable, until rd_ack is sampled high.
  - One transfer per cycle in which rd_req and rd_ack are both high, so acknowledgement every cycle is allowed.
  - rd_ack is ignored while rd_req=0.
- On each acknowledged transfer:
  - rd_addr increments by 1, modulo 2^ADDR_BITS (silent wrap, no flag).
  - If col != width-1: col increments by 1.
  - Else (end of row): col=0 and row_done=1 for the next cycle.
    - If row != height-1: row increments by 1.
    - Else: state=DONE, rd_req=0, and row/col hold their final values.
- DONE: frame_done=1 for exactly one cycle, then IDLE with busy=0, rd_req=0 and col=row=0. rd_addr holds its last value.
- Last row: row_done and frame_done assert in the same cycle (the cycle after the final acknowledgement).
- Latency: frame_done is asserted one cycle after the final acknowledgement; busy falls one cycle after that.
- start is ignored outside IDLE, and dimension or address input changes are ignored outside IDLE.
- clear during READ: state=IDLE and all outputs take their reset values at the next edge; no further requests. A later start restarts from the new base_addr.
- Counter arithmetic is unsigned at WIDTH_BITS. The boundary width-1 is computed from the latched width. Width 1 rolls col over on every acknowledgement.

Test Plan:
1. w=10, h=2, base=0x000100, rd_ack held high -> 20 requests at addresses 0x000100..0x000113; row_done high the cycle after the 10th and 20th acks; frame_done high the cycle after the 20th ack; busy low one cycle later.
2. w=3, h=1, rd_ack high only every 4th cycle -> rd_addr/col stable between acks; col sequence 0,1,2; exactly 3 transfers; frame_done once.
3. start with w=0, h=5 -> rd_req never asserted; frame_done=1 at k+1; IDLE at k+2.
4. w=10, h=4, clear asserted after the 5th ack -> next cycle rd_req=0, col=row=0, busy=0; new start with base=0x000400 -> first rd_addr=0x000400.
5. w=8191, h=1, base=0xFFFFF0, rd_ack held high -> address wraps 0xFFFFFF to 0x000000 after 16 acks; last address 0x001FEE; col reaches 8190, then row_done and frame_done assert together.
6. start re-pulsed mid-frame with different w/h/base -> ignored; the frame completes with the original parameters and request count.

Source files
------------

// File: rtl/i_rd_addr_gen.sv
// Read-side address generator: walks an image in SRAM in row-major order,
// one req/ack transfer per pixel, with row and frame completion strobes.
module i_rd_addr_gen #(
    parameter int WIDTH_BITS = 13,
    parameter int ADDR_BITS  = 24
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [WIDTH_BITS-1:0] img_width,
    input  logic [WIDTH_BITS-1:0] img_height,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic                  rd_ack,
    output logic                  rd_req,
    output logic [ADDR_BITS-1:0]  rd_addr,
    output logic [WIDTH_BITS-1:0] col,
    output logic [WIDTH_BITS-1:0] row,
    output logic                  row_done,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH_BITS-1:0] W_ZERO = {WIDTH_BITS{1'b0}};
    localparam logic [WIDTH_BITS-1:0] W_ONE  = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0]  A_ZERO = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0]  A_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Counter helpers; address wraps silently at 2^ADDR_BITS.
    function automatic logic [WIDTH_BITS-1:0] inc_w(input logic [WIDTH_BITS-1:0] v);
        return v + W_ONE;
    endfunction

    function automatic logic [ADDR_BITS-1:0] inc_a(input logic [ADDR_BITS-1:0] v);
        return v + A_ONE;
    endfunction

    logic [1:0]            state_r,      state_s;
    logic [WIDTH_BITS-1:0] width_r,      width_s;
    logic [WIDTH_BITS-1:0] height_r,     height_s;
    logic [ADDR_BITS-1:0]  base_r,       base_s;
    logic [ADDR_BITS-1:0]  rd_addr_r,    rd_addr_s;
    logic [WIDTH_BITS-1:0] col_r,        col_s;
    logic [WIDTH_BITS-1:0] row_r,        row_s;
    logic                  rd_req_r,     rd_req_s;
    logic                  row_done_r,   row_done_s;
    logic                  frame_done_r, frame_done_s;
    logic                  busy_r,       busy_s;

    logic xfer_s;
    logic last_col_s;
    logic last_row_s;
    logic dim_zero_s;

    // Transfer qualification and end-of-row/frame boundaries from latched dimensions.
    always_comb begin
        xfer_s     = rd_req_r & rd_ack;
        last_col_s = (col_r == (width_r - W_ONE));
        last_row_s = (row_r == (height_r - W_ONE));
        dim_zero_s = (img_width == W_ZERO) | (img_height == W_ZERO);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s      = state_r;
        width_s      = width_r;
        height_s     = height_r;
        base_s       = base_r;
        rd_addr_s    = rd_addr_r;
        col_s        = col_r;
        row_s        = row_r;
        rd_req_s     = rd_req_r;
        busy_s       = busy_r;
        row_done_s   = 1'b0;
        frame_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (dim_zero_s) begin
                        // Empty frame: report completion without issuing any request.
                        state_s      = ST_DONE;
                        frame_done_s = 1'b1;
                        busy_s       = 1'b1;
                    end else begin
                        state_s   = ST_READ;
                        width_s   = img_width;
                        height_s  = img_height;
                        base_s    = base_addr;
                        rd_addr_s = base_addr;
                        col_s     = W_ZERO;
                        row_s     = W_ZERO;
                        rd_req_s  = 1'b1;
                        busy_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_READ: begin
                if (xfer_s) begin
                    rd_addr_s = inc_a(rd_addr_r);
                    if (!last_col_s) begin
                        col_s = inc_w(col_r);
                    end else begin
                        row_done_s = 1'b1;
                        if (!last_row_s) begin
                            col_s = W_ZERO;
                            row_s = inc_w(row_r);
                        end else begin
                            // Final pixel: col/row keep their last values through DONE.
                            state_s      = ST_DONE;
                            rd_req_s     = 1'b0;
                            frame_done_s = 1'b1;
                        end
                    end
                end else begin
                    state_s = ST_READ;
                end
            end

            ST_DONE: begin
                state_s  = ST_IDLE;
                rd_req_s = 1'b0;
                busy_s   = 1'b0;
                col_s    = W_ZERO;
                row_s    = W_ZERO;
            end

            default: begin
                state_s  = ST_IDLE;
                rd_req_s = 1'b0;
                busy_s   = 1'b0;
                col_s    = W_ZERO;
                row_s    = W_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r      <= ST_IDLE;
            width_r      <= W_ZERO;
            height_r     <= W_ZERO;
            base_r       <= A_ZERO;
            rd_addr_r    <= A_ZERO;
            col_r        <= W_ZERO;
            row_r        <= W_ZERO;
            rd_req_r     <= 1'b0;
            row_done_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            width_r      <= width_s;
            height_r     <= height_s;
            base_r       <= base_s;
            rd_addr_r    <= rd_addr_s;
            col_r        <= col_s;
            row_r        <= row_s;
            rd_req_r     <= rd_req_s;
            row_done_r   <= row_done_s;
            frame_done_r <= frame_done_s;
            busy_r       <= busy_s;
        end
    end

    assign rd_req     = rd_req_r;
    assign rd_addr    = rd_addr_r;
    assign col        = col_r;
    assign row        = row_r;
    assign row_done   = row_done_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_i_rd_addr_gen.sv
// Bench for i_rd_addr_gen: directed frames plus randomized frames, checked every
// cycle against a pixel-index model of the raster read.
module tb_i_rd_addr_gen;

    localparam int WB = 13;
    localparam int AB = 24;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [WB-1:0] img_width;
    logic [WB-1:0] img_height;
    logic [AB-1:0] base_addr;
    logic          rd_ack;
    logic          rd_req;
    logic [AB-1:0] rd_addr;
    logic [WB-1:0] col;
    logic [WB-1:0] row;
    logic          row_done;
    logic          frame_done;
    logic          busy;

    i_rd_addr_gen #(.WIDTH_BITS(WB), .ADDR_BITS(AB)) dut (
        .clk(clk), .clear(clear), .start(start),
        .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
        .rd_ack(rd_ack), .rd_req(rd_req), .rd_addr(rd_addr),
        .col(col), .row(row), .row_done(row_done), .frame_done(frame_done), .busy(busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef enum int {M_IDLE, M_READ, M_DONE} mode_t;
    mode_t         m_mode = M_IDLE;
    int            m_w = 0, m_h = 0, m_idx = 0, m_col = 0, m_row = 0, m_acks = 0;
    logic [AB-1:0] m_base = '0;
    logic [AB-1:0] m_addr = '0;
    bit            m_rdone = 1'b0, m_fdone = 1'b0;
    int            obs_xfers = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pixel-index model: expected request is pixel m_idx of a w x h raster.
    task automatic model_update(input bit c, input bit s, input bit a,
                                input int w, input int h, input logic [AB-1:0] b);
        m_rdone = 1'b0;
        m_fdone = 1'b0;
        if (c) begin
            m_mode = M_IDLE; m_addr = '0; m_col = 0; m_row = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin
                    if (w == 0 || h == 0) begin
                        m_mode = M_DONE; m_fdone = 1'b1;
                    end else begin
                        m_w = w; m_h = h; m_base = b; m_idx = 0;
                        m_mode = M_READ; m_addr = b; m_col = 0; m_row = 0;
                    end
                end
                M_READ: if (a) begin
                    m_acks++;
                    if (m_idx % m_w == m_w - 1) m_rdone = 1'b1;
                    if (m_idx == m_w * m_h - 1) begin
                        m_mode = M_DONE; m_fdone = 1'b1;
                        m_addr = m_base + AB'(m_idx + 1);
                    end else begin
                        m_idx++;
                        m_col = m_idx % m_w;
                        m_row = m_idx / m_w;
                        m_addr = m_base + AB'(m_idx);
                    end
                end
                default: begin
                    m_mode = M_IDLE; m_col = 0; m_row = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        bit            c = clear;
        bit            s = start;
        bit            a = rd_ack;
        int            w = int'(img_width);
        int            h = int'(img_height);
        logic [AB-1:0] b = base_addr;
        if (rd_req && rd_ack) obs_xfers++;
        @(posedge clk);
        model_update(c, s, a, w, h, b);
        #1;
        chk("rd_req",     rd_req,     (m_mode == M_READ));
        chk("busy",       busy,       (m_mode != M_IDLE));
        chk("row_done",   row_done,   m_rdone);
        chk("frame_done", frame_done, m_fdone);
        chk("col",        col,        m_col);
        chk("row",        row,        m_row);
        chk("rd_addr",    rd_addr,    m_addr);
    endtask

    // ack_mode: 0 always, 1 every 4th cycle, 2 random. clr_at < 0 disables clear.
    task automatic run_frame(input int w, input int h, input logic [AB-1:0] b,
                             input int ack_mode, input int clr_at, input bit repulse);
        int budget = 0;
        bit cleared = 1'b0;
        img_width  = WB'(w);
        img_height = WB'(h);
        base_addr  = b;
        start      = 1'b1;
        rd_ack     = 1'($urandom_range(0, 1));
        obs_xfers  = 0;
        m_acks     = 0;
        step();
        start = 1'b0;
        while (m_mode != M_IDLE && budget < 20000) begin
            budget++;
            case (ack_mode)
                0:       rd_ack = 1'b1;
                1:       rd_ack = (budget % 4 == 0);
                default: rd_ack = 1'($urandom_range(0, 1));
            endcase
            if (clr_at >= 0 && m_acks == clr_at && !cleared) begin
                clear = 1'b1; cleared = 1'b1;
            end else begin
                clear = 1'b0;
            end
            if (repulse && budget == 3 && m_mode == M_READ) begin
                start      = 1'b1;
                img_width  = WB'(w + 3);
                img_height = WB'(h + 1);
                base_addr  = b + 24'h000055;
            end else begin
                start = 1'b0;
            end
            step();
        end
        clear = 1'b0;
        start = 1'b0;
        rd_ack = 1'b0;
        chk("timeout", (budget < 20000), 1'b1);
        if (!cleared) chk("xfers", obs_xfers, w * h);
        step();
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; rd_ack = 1'b0;
        img_width = '0; img_height = '0; base_addr = '0;
        step();
        step();
        clear = 1'b0;
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;

        run_frame(10, 2, 24'h000100, 0, -1, 1'b0);
        run_frame(3, 1, 24'h000200, 1, -1, 1'b0);
        run_frame(0, 5, 24'h000300, 0, -1, 1'b0);
        run_frame(10, 4, 24'h000350, 0, 5, 1'b0);
        run_frame(10, 4, 24'h000400, 0, -1, 1'b0);
        run_frame(8191, 1, 24'hFFFFF0, 0, -1, 1'b0);
        run_frame(4, 3, 24'h000500, 2, -1, 1'b1);
        run_frame(1, 4, 24'h000600, 2, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int w = $urandom_range(0, 7);
            int h = $urandom_range(0, 5);
            int am = $urandom_range(0, 2);
            int ca = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : -1;
            bit rp = 1'($urandom_range(0, 1));
            if (w == 0 && $urandom_range(0, 3) != 0) w = 1;
            run_frame(w, h, AB'($urandom), am, ca, rp);
            repeat ($urandom_range(0, 3)) begin
                rd_ack = 1'($urandom_range(0, 1));
                step();
            end
            rd_ack = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
